// File: rtl/main_control_fsm.sv
// Multicycle main controller for the RV32I core: sequences each instruction
// through fetch/decode/execute/memory/writeback and drives the datapath enables.
module main_control_fsm #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_update,
    output logic       branch,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [2:0] alu_op,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_AUIPC    = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] ALU_ADD    = 3'd0;
    localparam logic [2:0] ALU_BRANCH = 3'd1;
    localparam logic [2:0] ALU_RFUNCT = 3'd2;
    localparam logic [2:0] ALU_IFUNCT = 3'd3;
    localparam logic [2:0] ALU_PASSB  = 3'd4;

    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_MEM    = 2'd1;

    state_t cur_state;
    state_t nxt_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= state_t'(RESET_STATE);
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = S_FETCH;
        unique case (cur_state)
            S_FETCH:    nxt_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                unique case (opcode)
                    OP_LOAD,
                    OP_STORE:  nxt_state = S_MEMADR;
                    OP_RTYPE:  nxt_state = S_EXECR;
                    OP_ITYPE:  nxt_state = S_EXECI;
                    OP_BRANCH: nxt_state = S_BRANCH;
                    OP_JAL:    nxt_state = S_JAL;
                    OP_JALR:   nxt_state = S_JALR;
                    OP_LUI:    nxt_state = S_LUI;
                    OP_AUIPC:  nxt_state = S_AUIPC;
                    default:   nxt_state = S_TRAP;
                endcase
            end
            S_MEMADR:   nxt_state = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  nxt_state = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    nxt_state = S_FETCH;
            S_MEMWRITE: nxt_state = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR,
            S_EXECI,
            S_LUI,
            S_AUIPC:    nxt_state = S_ALUWB;
            S_ALUWB:    nxt_state = S_FETCH;
            S_BRANCH:   nxt_state = S_FETCH;
            S_JAL:      nxt_state = S_ALUWB;
            S_JALR:     nxt_state = S_JAL;
            S_TRAP:     nxt_state = S_TRAP;
            // Unencoded value 15 recovers to FETCH.
            default:    nxt_state = S_FETCH;
        endcase
    end

    // Outputs are forced low while reset is high so no write can slip out.
    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_op     = ALU_ADD;
        illegal    = 1'b0;
        state      = cur_state;
        unique case (cur_state)
            S_FETCH: begin
                mem_req   = 1'b1;
                ir_write  = mem_ready;
                pc_update = mem_ready;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                result_src = RES_MEM;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
            end
            S_EXECR:  alu_op = ALU_RFUNCT;
            S_EXECI:  alu_op = ALU_IFUNCT;
            S_LUI:    alu_op = ALU_PASSB;
            S_ALUWB:  reg_write = 1'b1;
            S_BRANCH: begin
                alu_op = ALU_BRANCH;
                branch = 1'b1;
            end
            S_JAL:    pc_update = 1'b1;
            S_TRAP:   illegal = 1'b1;
            default: ;
        endcase
        if (reset) begin
            mem_req    = 1'b0;
            mem_write  = 1'b0;
            adr_src    = 1'b0;
            ir_write   = 1'b0;
            pc_update  = 1'b0;
            branch     = 1'b0;
            reg_write  = 1'b0;
            result_src = RES_ALUOUT;
            alu_op     = ALU_ADD;
            illegal    = 1'b0;
            state      = 4'd0;
        end
    end

endmodule

// File: tb/tb_main_control_fsm.sv
// Scoreboard bench for main_control_fsm: the driver queues the expected
// per-cycle outputs, a monitor on the falling edge pops and compares them.
module tb_main_control_fsm;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_update;
        logic       branch;
        logic       reg_write;
        logic [1:0] result_src;
        logic [2:0] alu_op;
        logic       illegal;
    } out_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       mem_req, mem_write, adr_src, ir_write, pc_update;
    logic       branch, reg_write, illegal;
    logic [1:0] result_src;
    logic [2:0] alu_op;
    logic [3:0] state;

    out_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;
    logic  finish_req = 1'b0;

    localparam logic [6:0] ADD  = 7'b0110011;
    localparam logic [6:0] ADDI = 7'b0010011;
    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] LUI  = 7'b0110111;
    localparam logic [6:0] AUI  = 7'b0010111;
    localparam logic [6:0] BAD  = 7'b1111111;

    main_control_fsm #(.RESET_STATE(4'd0)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_update  (pc_update),
        .branch     (branch),
        .reg_write  (reg_write),
        .result_src (result_src),
        .alu_op     (alu_op),
        .illegal    (illegal),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Hand-derived output table per state; FETCH strobes follow mem_ready.
    function automatic out_t expv(input int st, input logic rdy);
        out_t e;
        e = '0;
        e.st = 4'(st);
        case (st)
            0:  begin e.mem_req = 1'b1; e.ir_write = rdy; e.pc_update = rdy; end
            3:  begin e.mem_req = 1'b1; e.adr_src = 1'b1; end
            4:  begin e.reg_write = 1'b1; e.result_src = 2'd1; end
            5:  begin e.mem_req = 1'b1; e.mem_write = 1'b1; e.adr_src = 1'b1; end
            6:  e.alu_op = 3'd2;
            7:  e.alu_op = 3'd3;
            8:  e.reg_write = 1'b1;
            9:  begin e.alu_op = 3'd1; e.branch = 1'b1; end
            10: e.pc_update = 1'b1;
            12: e.alu_op = 3'd4;
            14: e.illegal = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    // Called one time unit after a rising edge; covers exactly one cycle.
    task automatic step(input int st, input logic rdy, input logic [6:0] opc, input string tag);
        mem_ready = rdy;
        opcode    = opc;
        exp_q.push_back(expv(st, rdy));
        tag_q.push_back($sformatf("%s_s%0d", tag, st));
        @(posedge clk);
        #1;
    endtask

    task automatic push_zero(input string tag);
        exp_q.push_back('0);
        tag_q.push_back(tag);
    endtask

    task automatic reset_pulse(input string tag);
        reset = 1'b1;
        push_zero({tag, "_async"});
        @(posedge clk);
        #1;
        push_zero({tag, "_hold"});
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin : monitor
        out_t  act;
        out_t  e;
        string t;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                act = {state, mem_req, mem_write, adr_src, ir_write, pc_update,
                       branch, reg_write, result_src, alu_op, illegal};
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: got st=%0d req=%b wr=%b adr=%b ir=%b pc=%b br=%b rw=%b rs=%0d alu=%0d ill=%b, expected st=%0d req=%b wr=%b adr=%b ir=%b pc=%b br=%b rw=%b rs=%0d alu=%0d ill=%b",
                             t, act.st, act.mem_req, act.mem_write, act.adr_src, act.ir_write,
                             act.pc_update, act.branch, act.reg_write, act.result_src, act.alu_op,
                             act.illegal, e.st, e.mem_req, e.mem_write, e.adr_src, e.ir_write,
                             e.pc_update, e.branch, e.reg_write, e.result_src, e.alu_op, e.illegal);
                end
            end else if (finish_req) begin
                checks++;
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
                end
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

    initial begin : driver
        reset     = 1'b1;
        opcode    = 7'd0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        push_zero("por");
        @(posedge clk);
        #1;
        reset = 1'b0;

        step(0, 1'b1, ADD, "add"); step(1, 1'b0, ADD, "add");
        step(6, 1'b1, ADD, "add"); step(8, 1'b0, ADD, "add");

        step(0, 1'b1, ADD, "rst"); step(1, 1'b1, ADD, "rst");
        reset_pulse("rst_execr");
        step(0, 1'b0, ADD, "rst_rel");
        step(0, 1'b1, LW, "lw");
        step(1, 1'b0, LW, "lw"); step(2, 1'b1, LW, "lw");
        step(3, 1'b0, LW, "lw"); step(3, 1'b0, LW, "lw"); step(3, 1'b1, LW, "lw");
        step(4, 1'b0, LW, "lw");

        for (int i = 0; i < 3; i++) step(0, 1'b0, LUI, "fstall");
        step(0, 1'b1, LUI, "fstall"); step(1, 1'b0, LUI, "lui");
        step(12, 1'b1, LUI, "lui"); step(8, 1'b1, LUI, "lui");

        step(0, 1'b1, BEQ, "beq"); step(1, 1'b1, BEQ, "beq"); step(9, 1'b0, BEQ, "beq");

        step(0, 1'b1, JALR, "jalr"); step(1, 1'b1, JALR, "jalr");
        step(11, 1'b0, JALR, "jalr"); step(10, 1'b1, JALR, "jalr");
        step(8, 1'b0, JALR, "jalr");

        step(0, 1'b1, SW, "sw"); step(1, 1'b1, SW, "sw"); step(2, 1'b0, SW, "sw");
        step(5, 1'b0, SW, "sw"); step(5, 1'b1, SW, "sw");

        step(0, 1'b1, ADDI, "addi"); step(1, 1'b1, ADDI, "addi");
        step(7, 1'b1, ADDI, "addi"); step(8, 1'b1, ADDI, "addi");
        step(0, 1'b1, AUI, "auipc"); step(1, 1'b0, AUI, "auipc");
        step(13, 1'b1, AUI, "auipc"); step(8, 1'b0, AUI, "auipc");
        step(0, 1'b1, JAL, "jal"); step(1, 1'b1, JAL, "jal");
        step(10, 1'b0, JAL, "jal"); step(8, 1'b1, JAL, "jal");

        step(0, 1'b1, BAD, "trap"); step(1, 1'b0, BAD, "trap");
        for (int i = 0; i < 12; i++) step(14, 1'(i % 2), BAD, "trap");
        reset_pulse("rst_trap");
        step(0, 1'b0, ADD, "post_trap");
        step(0, 1'b1, ADD, "post_trap");
        step(1, 1'b0, ADD, "post_trap");

        finish_req = 1'b1;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
